// File: rtl/rx_scan_pkg.sv
// rtl/rx_scan_pkg.sv - shared types and constants for the receive-channel scan scheduler
// Contents: FSM state enum, channel index width, channel-to-mux-address table.
package rx_scan_pkg;

    localparam int CH_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONVERT,
        ST_ADVANCE,
        ST_DONE
    } state_t;

    // Channel index -> mux address. Identity today; a board-level remap of the
    // analog mux inputs is made here and nowhere else.
    localparam logic [7:0][CH_W-1:0] CH_ADDR_TBL = {
        3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0
    };

    function automatic logic [CH_W-1:0] ch_to_addr(input logic [CH_W-1:0] ch);
        return CH_ADDR_TBL[ch];
    endfunction

endpackage

// File: rtl/rx_scan_timer.sv
// rtl/rx_scan_timer.sv - loadable down-counter with expiry flag
// Ports:
//   clks     in   system clock
//   rst      in   synchronous active-high reset
//   load     in   load load_val (has priority over dec)
//   dec      in   decrement, saturating at zero
//   load_val in   W-bit reload value
//   count    out  current count
//   expired  out  count is zero
module rx_scan_timer #(
    parameter int W = 16
) (
    input  logic         clks,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         expired
);

    always_ff @(posedge clks) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/rx_scan_sched.sv
// rtl/rx_scan_sched.sv - receive-channel scan scheduler for an 8:1 analog receive mux
// Optional feature macro: RX_SCAN_TIMEOUT_EN (CONVERT watchdog and timeout_err).
// Ports:
//   clks        in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   scan_start  in   pulse: begin a scan (ignored while busy)
//   start_ch    in   first channel, sampled with scan_start
//   adc_done    in   pulse: ADC summation finished (accepted only in CONVERT)
//   mux_addr    out  registered mux address
//   mux_en      out  mux enable, high SETTLE..ADVANCE
//   adc_start   out  pulse: start ADC summation for current channel
//   ch_idx      out  channel currently being received
//   ch_done     out  pulse on accepted adc_done
//   busy        out  high outside IDLE
//   scan_done   out  pulse after the last channel
//   timeout_err out  sticky watchdog error (0 without RX_SCAN_TIMEOUT_EN)
module rx_scan_sched
    import rx_scan_pkg::*;
#(
    parameter int NUM_CH      = 7,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic            clks,
    input  logic            rst,
    input  logic            scan_start,
    input  logic [CH_W-1:0] start_ch,
    input  logic            adc_done,
    output logic [CH_W-1:0] mux_addr,
    output logic            mux_en,
    output logic            adc_start,
    output logic [CH_W-1:0] ch_idx,
    output logic            ch_done,
    output logic            busy,
    output logic            scan_done,
    output logic            timeout_err
);

    // One timer serves both settle and watchdog, so it is sized for the larger.
    localparam int TMR_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [CH_W-1:0]   first_ch;
    logic [CH_W-1:0]   next_ch;
    logic              last_ch;

    logic              tmr_load;
    logic              tmr_dec;
    logic [TMR_W-1:0]  tmr_val;
    logic [TMR_W-1:0]  tmr_cnt;
    logic              tmr_expired;

    assign first_ch = ({1'b0, start_ch} >= 4'(NUM_CH)) ? '0 : start_ch;
    // Explicit wrap so a non-power-of-two NUM_CH never drives an unused address.
    assign next_ch  = (ch_idx == CH_W'(NUM_CH - 1)) ? '0 : ch_idx + 1'b1;
    // cnt is 4 bits so NUM_CH=8 compares against 8, not an aliased 0.
    assign last_ch  = (cnt == 4'(NUM_CH));

    // Timer is loaded with SETTLE_CYC-1 on SETTLE entry; SETTLE ends on the
    // cycle it reads zero, giving exactly SETTLE_CYC cycles of address hold.
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = TMR_W'(SETTLE_CYC - 1);
        case (state)
            ST_IDLE:    tmr_load = scan_start;
            ST_SETTLE: begin
                tmr_dec = 1'b1;
`ifdef RX_SCAN_TIMEOUT_EN
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
                end
`endif
            end
`ifdef RX_SCAN_TIMEOUT_EN
            ST_CONVERT: tmr_dec = 1'b1;
`endif
            ST_ADVANCE: tmr_load = !last_ch;
            default:    ;
        endcase
    end

    rx_scan_timer #(.W(TMR_W)) u_timer (
        .clks     (clks),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .count    (tmr_cnt),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clks) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mux_addr  <= '0;
            mux_en    <= 1'b0;
            adc_start <= 1'b0;
            ch_idx    <= '0;
            ch_done   <= 1'b0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
`ifdef RX_SCAN_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            adc_start <= 1'b0;
            ch_done   <= 1'b0;
            scan_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (scan_start) begin
                        ch_idx    <= first_ch;
                        mux_addr  <= ch_to_addr(first_ch);
                        cnt       <= '0;
                        mux_en    <= 1'b1;
                        busy      <= 1'b1;
                        // With a one-cycle settle the pulse lands in the first SETTLE cycle.
                        adc_start <= (SETTLE_CYC == 1);
`ifdef RX_SCAN_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // adc_start is registered, so it is raised one cycle ahead
                    // to coincide with the final SETTLE cycle.
                    if (tmr_expired) begin
                        state <= ST_CONVERT;
                    end else begin
                        adc_start <= (tmr_cnt == TMR_W'(1));
                    end
                end
                ST_CONVERT: begin
                    if (adc_done) begin
                        ch_done <= 1'b1;
                        cnt     <= cnt + 4'd1;
                        state   <= ST_ADVANCE;
                    end
`ifdef RX_SCAN_TIMEOUT_EN
                    else if (tmr_expired) begin
                        timeout_err <= 1'b1;
                        cnt         <= cnt + 4'd1;
                        state       <= ST_ADVANCE;
                    end
`endif
                end
                ST_ADVANCE: begin
                    if (last_ch) begin
                        mux_en    <= 1'b0;
                        scan_done <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        ch_idx    <= next_ch;
                        mux_addr  <= ch_to_addr(next_ch);
                        adc_start <= (SETTLE_CYC == 1);
                        state     <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef RX_SCAN_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule
